// File: rtl/control_riego_if.sv
// Irrigation sequencer bus: setpoint frame, live sensor/RTC inputs and pump/status outputs.
// The optional manual pushbutton line exists only when MANUAL_RIEGO_EN is defined.
interface control_riego_if;
  logic        listo;
  logic [11:0] humedad;
  logic [15:0] hora;
  logic [3:0]  tipoPlanta;
  logic [11:0] humedad_act;
  logic [15:0] hora_act;
  logic        tick_seg;
`ifdef MANUAL_RIEGO_EN
  logic        manual;
`endif
  logic        bomba;
  logic [2:0]  estado;
  logic        cfg_ok;
  logic        cfg_err;
  logic        riego_hecho;
  logic        alarma;

  modport master (
`ifdef MANUAL_RIEGO_EN
    output manual,
`endif
    output listo, humedad, hora, tipoPlanta, humedad_act, hora_act, tick_seg,
    input  bomba, estado, cfg_ok, cfg_err, riego_hecho, alarma
  );

  modport slave (
`ifdef MANUAL_RIEGO_EN
    input  manual,
`endif
    input  listo, humedad, hora, tipoPlanta, humedad_act, hora_act, tick_seg,
    output bomba, estado, cfg_ok, cfg_err, riego_hecho, alarma
  );
endinterface

// File: rtl/control_riego.sv
// Irrigation sequencer: validated setpoint frame, scheduled moisture check, bursts with soak pauses.
// Optional MANUAL_RIEGO_EN adds a synchronized pushbutton that starts/aborts a burst.
module control_riego #(
  parameter int SOAK_S     = 30,
  parameter int MAX_CICLOS = 3,
  parameter int TIMER_W    = 8
) (
  input logic            clk,
  input logic            rst_n,
  control_riego_if.slave b
);
  typedef enum logic [2:0] {
    SIN_CFG = 3'd0,
    MONITOR = 3'd1,
    REGANDO = 3'd2,
    REMOJO  = 3'd3,
    FALLA   = 3'd4
  } st_t;

  function automatic logic dig_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  function automatic logic hum_ok(input logic [11:0] h);
    return dig_ok(h[11:8]) && dig_ok(h[7:4]) && dig_ok(h[3:0]);
  endfunction

  // With valid digits, packed BCD compares like decimal, so hh<=0x23 and mm<=0x59 suffice.
  function automatic logic hora_ok(input logic [15:0] t);
    return dig_ok(t[15:12]) && dig_ok(t[11:8]) && dig_ok(t[7:4]) && dig_ok(t[3:0]) &&
           (t[15:8] <= 8'h23) && (t[7:0] <= 8'h59);
  endfunction

  function automatic logic [TIMER_W-1:0] dur(input logic [3:0] tp);
    case (tp)
      4'd0:    return TIMER_W'(10);
      4'd1:    return TIMER_W'(20);
      4'd2:    return TIMER_W'(40);
      4'd3:    return TIMER_W'(60);
      default: return TIMER_W'(30);
    endcase
  endfunction

  st_t               st;
  logic [2:0]        listo_sh;
  logic [11:0]       sh_hum;
  logic [15:0]       sh_hora;
  logic [3:0]        sh_tipo;
  logic [TIMER_W-1:0] timer;
  logic [3:0]        cnt;
  logic              arm;
  logic              bomba_q, cfg_ok_q, cfg_err_q, hecho_q, alarma_q;

  logic frame_ev, frame_ok, seco, hit;
  assign frame_ev = listo_sh[1] & ~listo_sh[2];
  assign frame_ok = hum_ok(b.humedad) && hora_ok(b.hora);
  // Corrupt live digits must never look wet, or a broken sensor would suppress watering.
  assign seco     = !hum_ok(b.humedad_act) || (b.humedad_act < sh_hum);
  assign hit      = b.tick_seg && arm && (b.hora_act == sh_hora);

`ifdef MANUAL_RIEGO_EN
  logic [2:0] man_sh;
  logic       man_ev;
  assign man_ev = man_sh[1] & ~man_sh[2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= SIN_CFG;
      listo_sh  <= '0;
      sh_hum    <= '0;
      sh_hora   <= '0;
      sh_tipo   <= '0;
      timer     <= '0;
      cnt       <= '0;
      arm       <= 1'b0;
      bomba_q   <= 1'b0;
      cfg_ok_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      hecho_q   <= 1'b0;
      alarma_q  <= 1'b0;
`ifdef MANUAL_RIEGO_EN
      man_sh    <= '0;
`endif
    end else begin
      listo_sh <= {listo_sh[1:0], b.listo};
`ifdef MANUAL_RIEGO_EN
      man_sh   <= {man_sh[1:0], b.manual};
`endif
      hecho_q  <= 1'b0;
      if (b.tick_seg && timer != '0) timer <= timer - 1'b1;
      if (b.hora_act != sh_hora) arm <= 1'b1;
      if (frame_ev && !frame_ok) cfg_err_q <= 1'b1;

      // An accepted frame overrides whatever the sequencer would do this cycle.
      if (frame_ev && frame_ok) begin
        sh_hum    <= b.humedad;
        sh_hora   <= b.hora;
        sh_tipo   <= b.tipoPlanta;
        cfg_ok_q  <= 1'b1;
        cfg_err_q <= 1'b0;
        alarma_q  <= 1'b0;
        bomba_q   <= 1'b0;
        st        <= MONITOR;
      end else
`ifdef MANUAL_RIEGO_EN
      if (man_ev && cfg_ok_q && st == MONITOR) begin
        cnt     <= '0;
        timer   <= dur(sh_tipo);
        bomba_q <= 1'b1;
        st      <= REGANDO;
      end else if (man_ev && (st == REGANDO || st == REMOJO)) begin
        bomba_q <= 1'b0;
        st      <= MONITOR;
      end else
`endif
      begin
        case (st)
          SIN_CFG: bomba_q <= 1'b0;
          MONITOR: begin
            bomba_q <= 1'b0;
            if (hit) begin
              arm <= 1'b0;
              cnt <= '0;
              if (seco) begin
                timer   <= dur(sh_tipo);
                bomba_q <= 1'b1;
                st      <= REGANDO;
              end
            end
          end
          REGANDO: begin
            // Reaching the target beats a simultaneous timer expiry.
            if (!seco) begin
              hecho_q <= 1'b1;
              bomba_q <= 1'b0;
              st      <= MONITOR;
            end else if (timer == '0) begin
              cnt     <= cnt + 4'd1;
              bomba_q <= 1'b0;
              if (cnt + 4'd1 == 4'(MAX_CICLOS)) begin
                alarma_q <= 1'b1;
                st       <= FALLA;
              end else begin
                timer <= TIMER_W'(SOAK_S);
                st    <= REMOJO;
              end
            end else begin
              bomba_q <= 1'b1;
            end
          end
          REMOJO: begin
            bomba_q <= 1'b0;
            if (timer == '0) begin
              if (!seco) begin
                hecho_q <= 1'b1;
                st      <= MONITOR;
              end else begin
                timer   <= dur(sh_tipo);
                bomba_q <= 1'b1;
                st      <= REGANDO;
              end
            end
          end
          FALLA: begin
            bomba_q  <= 1'b0;
            alarma_q <= 1'b1;
          end
          default: begin
            bomba_q <= 1'b0;
            st      <= SIN_CFG;
          end
        endcase
      end
    end
  end

  assign b.bomba       = bomba_q;
  assign b.estado      = st;
  assign b.cfg_ok      = cfg_ok_q;
  assign b.cfg_err     = cfg_err_q;
  assign b.riego_hecho = hecho_q;
  assign b.alarma      = alarma_q;
endmodule
